// File: rtl/pwm_pkg.sv
// Shared state encoding and sizing helper for the PWM generator and its tests.
package pwm_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} pwm_state_t;

  // Number of PWM counts in one period for a given duty width.
  function automatic int unsigned pwm_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Count-rate divider: tick_out is high for one clock every div_in+1 clocks.
// clear_in restarts the division so a new period begins on a full prescale slot.
module prescaler_tick #(
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      clear_in,
  input  logic [PRESCALE_WIDTH-1:0] div_in,
  output logic                      tick_out
);

  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

  assign tick_out = (cnt_q == div_in);

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + PRESCALE_WIDTH'(1);
    if (clear_in || tick_out) cnt_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_generator.sv
// PWM generator with period-boundary latching of duty and prescale, so the
// output never glitches when the motor command changes mid-period.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int unsigned DUTY_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      enable_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale_in,
  input  logic [DUTY_WIDTH-1:0]     duty_in,
  output logic                      pwm_out,
  output logic                      period_start_out,
  output logic [DUTY_WIDTH-1:0]     duty_applied_out,
  output logic                      busy_out
);

  localparam logic [DUTY_WIDTH-1:0] LAST_CNT = DUTY_WIDTH'(pwm_max(DUTY_WIDTH) - 32'd1);

  pwm_state_t                state_q, state_d;
  logic [DUTY_WIDTH-1:0]     duty_q, duty_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [DUTY_WIDTH-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic                      pwm_q, pwm_d;
  logic                      period_start_q, period_start_d;
  logic                      tick, period_end, load, active;

  prescaler_tick #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_prescaler (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear_in (load),
    .div_in   (prescale_q),
    .tick_out (tick)
  );

  assign active     = (state_q != IDLE);
  assign period_end = tick && (pwm_cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: if (enable_in) begin
        state_d = RUN;
        load    = 1'b1;
      end
      RUN: begin
        if (!enable_in)      state_d = DRAIN;
        else if (period_end) load    = 1'b1;
      end
      DRAIN: begin
        if (enable_in) begin
          state_d = RUN;
          load    = period_end;
        end else if (period_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    duty_d         = load ? duty_in : duty_q;
    prescale_d     = load ? prescale_in : prescale_q;
    pwm_cnt_d      = pwm_cnt_q;
    if (load)                 pwm_cnt_d = '0;
    else if (active && tick)  pwm_cnt_d = period_end ? '0 : pwm_cnt_q + DUTY_WIDTH'(1);
    pwm_d          = active && (pwm_cnt_q < duty_q);
    period_start_d = load;
  end

  // NOTE: the duty/prescale latches are plain registers and are reset with everything else so all outputs read 0 out of reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      duty_q         <= '0;
      prescale_q     <= '0;
      pwm_cnt_q      <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      duty_q         <= duty_d;
      prescale_q     <= prescale_d;
      pwm_cnt_q      <= pwm_cnt_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_out          = pwm_q;
  assign period_start_out = period_start_q;
  assign duty_applied_out = duty_q;
  assign busy_out         = active;

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator (DUTY_WIDTH=8, MAX=255): period lengths,
// high-time counts, boundary latching, drain behaviour and mid-run reset.
module tb_pwm_generator;

  localparam int DW = 8;
  localparam int PW = 16;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          enable_in;
  logic [PW-1:0] prescale_in;
  logic [DW-1:0] duty_in;
  logic          pwm_out;
  logic          period_start_out;
  logic [DW-1:0] duty_applied_out;
  logic          busy_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  pwm_generator #(.DUTY_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .enable_in        (enable_in),
    .prescale_in      (prescale_in),
    .duty_in          (duty_in),
    .pwm_out          (pwm_out),
    .period_start_out (period_start_out),
    .duty_applied_out (duty_applied_out),
    .busy_out         (busy_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic run_cycles(input int n, inout int len, inout int hi);
    for (int i = 0; i < n; i++) begin
      step(1);
      len++;
      hi += int'(pwm_out);
    end
  endtask

  // Steps until the next period_start_out pulse, counting cycles and high cycles.
  task automatic run_to_pulse(input string tag, inout int len, inout int hi);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      step(1);
      len++;
      hi += int'(pwm_out);
      if (period_start_out === 1'b1) seen = 1'b1;
    end
    check({tag, "_pulse_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int len;
    int hi;
    bit idle_seen;

    rst_in      = 1'b1;
    enable_in   = 1'b0;
    prescale_in = '0;
    duty_in     = '0;
    step(2);
    check("rst_pwm",   32'(pwm_out), 32'd0);
    check("rst_start", 32'(period_start_out), 32'd0);
    check("rst_duty",  32'(duty_applied_out), 32'd0);
    check("rst_busy",  32'(busy_out), 32'd0);
    rst_in = 1'b0;
    step(3);
    check("idle_busy", 32'(busy_out), 32'd0);
    check("idle_pwm",  32'(pwm_out), 32'd0);

    // 1: prescale 0, duty 128 -> 255-clock periods, 128 high.
    duty_in   = 8'd128;
    enable_in = 1'b1;
    step(1);
    check("t1_busy",  32'(busy_out), 32'd1);
    check("t1_start", 32'(period_start_out), 32'd1);
    check("t1_duty",  32'(duty_applied_out), 32'd128);
    for (int p = 0; p < 2; p++) begin
      len = 0; hi = 0;
      run_to_pulse("t1", len, hi);
      check("t1_len", 32'(len), 32'd255);
      check("t1_hi",  32'(hi),  32'd128);
    end

    // 2: duty 0 then 255, each taking effect at the next pulse.
    duty_in = 8'd0;
    len = 0; hi = 0;
    run_to_pulse("t2a", len, hi);
    check("t2_old_hi", 32'(hi), 32'd128);
    check("t2_duty0",  32'(duty_applied_out), 32'd0);
    duty_in = 8'd255;
    len = 0; hi = 0;
    run_to_pulse("t2b", len, hi);
    check("t2_zero_hi", 32'(hi), 32'd0);
    check("t2_duty255", 32'(duty_applied_out), 32'd255);
    len = 0; hi = 0;
    run_to_pulse("t2c", len, hi);
    check("t2_full_len", 32'(len), 32'd255);
    check("t2_full_hi",  32'(hi),  32'd255);

    // 3: duty 64 -> 200 mid-period keeps 64 for the current period.
    duty_in = 8'd64;
    len = 0; hi = 0;
    run_to_pulse("t3a", len, hi);
    check("t3_duty64", 32'(duty_applied_out), 32'd64);
    len = 0; hi = 0;
    run_cycles(100, len, hi);
    duty_in = 8'd200;
    step(1); len++; hi += int'(pwm_out);
    check("t3_duty_held", 32'(duty_applied_out), 32'd64);
    run_to_pulse("t3b", len, hi);
    check("t3_mid_len", 32'(len), 32'd255);
    check("t3_mid_hi",  32'(hi),  32'd64);
    check("t3_duty200", 32'(duty_applied_out), 32'd200);
    len = 0; hi = 0;
    run_to_pulse("t3c", len, hi);
    check("t3_new_hi", 32'(hi), 32'd200);

    // 4: prescale 3, duty 10 -> 1020-clock period, 40 high; mid-period change deferred.
    prescale_in = 16'd3;
    duty_in     = 8'd10;
    len = 0; hi = 0;
    run_to_pulse("t4a", len, hi);
    check("t4_old_len", 32'(len), 32'd255);
    len = 0; hi = 0;
    run_to_pulse("t4b", len, hi);
    check("t4_len", 32'(len), 32'd1020);
    check("t4_hi",  32'(hi),  32'd40);
    len = 0; hi = 0;
    run_cycles(300, len, hi);
    prescale_in = 16'd1;
    run_to_pulse("t4c", len, hi);
    check("t4_mid_len", 32'(len), 32'd1020);
    check("t4_mid_hi",  32'(hi),  32'd40);
    prescale_in = 16'd0;
    duty_in     = 8'd100;
    len = 0; hi = 0;
    run_to_pulse("t4d", len, hi);
    check("t4_p1_len", 32'(len), 32'd510);
    check("t4_p1_hi",  32'(hi),  32'd20);

    // 5: drop enable at count 50 of a duty-100 period; the period completes, then idle.
    check("t5_duty", 32'(duty_applied_out), 32'd100);
    len = 0; hi = 0;
    run_cycles(50, len, hi);
    enable_in = 1'b0;
    idle_seen = 1'b0;
    for (int i = 0; i < 400 && !idle_seen; i++) begin
      step(1);
      len++;
      hi += int'(pwm_out);
      if (busy_out === 1'b0) idle_seen = 1'b1;
    end
    check("t5_idle_seen", 32'(idle_seen), 32'd1);
    check("t5_drain_len", 32'(len), 32'd255);
    check("t5_drain_hi",  32'(hi),  32'd100);
    len = 0; hi = 0;
    run_cycles(20, len, hi);
    check("t5_idle_hi",   32'(hi), 32'd0);
    check("t5_idle_busy", 32'(busy_out), 32'd0);
    check("t5_duty_hold", 32'(duty_applied_out), 32'd100);

    // Re-enable; two short DRAIN excursions must not restart or truncate the period.
    enable_in = 1'b1;
    step(1);
    check("t5_restart_start", 32'(period_start_out), 32'd1);
    len = 0; hi = 0;
    run_cycles(30, len, hi);
    enable_in = 1'b0;
    run_cycles(1, len, hi);
    enable_in = 1'b1;
    run_cycles(100, len, hi);
    enable_in = 1'b0;
    run_cycles(3, len, hi);
    check("t5_drain_busy", 32'(busy_out), 32'd1);
    enable_in = 1'b1;
    run_to_pulse("t5r", len, hi);
    check("t5_nogap_len", 32'(len), 32'd255);
    check("t5_nogap_hi",  32'(hi),  32'd100);

    // 6: one-clock reset mid-RUN, then restart with enable held high.
    step(40);
    check("t6_pre_pwm", 32'(pwm_out), 32'd1);
    rst_in = 1'b1;
    step(1);
    check("t6_rst_pwm",   32'(pwm_out), 32'd0);
    check("t6_rst_busy",  32'(busy_out), 32'd0);
    check("t6_rst_start", 32'(period_start_out), 32'd0);
    check("t6_rst_duty",  32'(duty_applied_out), 32'd0);
    rst_in = 1'b0;
    step(1);
    check("t6_c1_busy",  32'(busy_out), 32'd1);
    check("t6_c1_start", 32'(period_start_out), 32'd1);
    check("t6_c1_pwm",   32'(pwm_out), 32'd0);
    check("t6_c1_duty",  32'(duty_applied_out), 32'd100);
    step(1);
    check("t6_c2_pwm",   32'(pwm_out), 32'd1);
    check("t6_c2_start", 32'(period_start_out), 32'd0);
    len = 1; hi = 1;
    run_to_pulse("t6", len, hi);
    check("t6_len", 32'(len), 32'd255);
    check("t6_hi",  32'(hi),  32'd100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
